// File: rtl/sap1_controller.sv
// SAP-1 control sequencer: six-state one-hot T-state ring clocked on the falling
// edge, with a combinational control-word decode and a sticky halt.
module sap1_controller #(
  parameter logic [3:0] OP_LDA = 4'h0,
  parameter logic [3:0] OP_ADD = 4'h1,
  parameter logic [3:0] OP_SUB = 4'h2,
  parameter logic [3:0] OP_OUT = 4'hE,
  parameter logic [3:0] OP_HLT = 4'hF
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lm_n,
  output logic       ce_n,
  output logic       li_n,
  output logic       la_n,
  output logic       lb_n,
  output logic       lo_n,
  output logic       ei_n,
  output logic       ea,
  output logic       eu,
  output logic       su,
  output logic       halt,
  output logic [5:0] tstate
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  tstate_e tstate_q, tstate_d;
  logic    halt_q, halt_d;

  logic is_mem_op;
  assign is_mem_op = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB);

  always_comb begin
    tstate_d = tstate_q;
    halt_d   = halt_q;
    case (tstate_q)
      T1: tstate_d = T2;
      T2: tstate_d = T3;
      T3: tstate_d = T4;
      // Halt can only ever be set here, so holding T4 covers the frozen ring.
      T4: begin
        if (halt_q || (opcode == OP_HLT)) halt_d = 1'b1;
        else                              tstate_d = T5;
      end
      T5: tstate_d = T6;
      T6: tstate_d = T1;
      default: tstate_d = T1;
    endcase
  end

  always_ff @(negedge clk or negedge clr) begin
    if (!clr) begin
      tstate_q <= T1;
      halt_q   <= 1'b0;
    end else begin
      tstate_q <= tstate_d;
      halt_q   <= halt_d;
    end
  end

  always_comb begin
    cp   = 1'b0;
    ep   = 1'b0;
    lm_n = 1'b1;
    ce_n = 1'b1;
    li_n = 1'b1;
    la_n = 1'b1;
    lb_n = 1'b1;
    lo_n = 1'b1;
    ei_n = 1'b1;
    ea   = 1'b0;
    eu   = 1'b0;
    su   = 1'b0;
    // Gating on clr keeps the word inactive for the whole reset, not just after the edge.
    if (clr && !halt_q) begin
      case (tstate_q)
        T1: begin ep = 1'b1; lm_n = 1'b0; end
        T2: cp = 1'b1;
        T3: begin ce_n = 1'b0; li_n = 1'b0; end
        T4: begin
          if (is_mem_op) begin
            ei_n = 1'b0;
            lm_n = 1'b0;
          end else if (opcode == OP_OUT) begin
            ea   = 1'b1;
            lo_n = 1'b0;
          end
        end
        T5: begin
          if (opcode == OP_LDA) begin
            ce_n = 1'b0;
            la_n = 1'b0;
          end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            ce_n = 1'b0;
            lb_n = 1'b0;
          end
        end
        T6: begin
          if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
            eu   = 1'b1;
            la_n = 1'b0;
            su   = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = tstate_q;
  assign halt   = halt_q;

endmodule

// File: tb/tb_sap1_controller.sv
// Self-checking bench for sap1_controller: directed scenarios plus random opcode
// streams compared against a table-driven model of the instruction timing.
module tb_sap1_controller;

  localparam logic [3:0] LDA = 4'h0;
  localparam logic [3:0] ADD = 4'h1;
  localparam logic [3:0] SUB = 4'h2;
  localparam logic [3:0] OUT = 4'hE;
  localparam logic [3:0] HLT = 4'hF;
  localparam logic [11:0] INACT = 12'b0011_1111_1000;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       cp, ep, lm_n, ce_n, li_n, la_n, lb_n, lo_n, ei_n, ea, eu, su, halt;
  logic [5:0] tstate;
  logic [11:0] cw;

  int total = 0;
  int bad   = 0;
  int mt    = 0;
  bit mhalt = 1'b0;

  always #5 clk = ~clk;

  assign cw = {cp, ep, lm_n, ce_n, li_n, la_n, lb_n, lo_n, ei_n, ea, eu, su};

  sap1_controller #(
    .OP_LDA(4'h0),
    .OP_ADD(4'h1),
    .OP_SUB(4'h2),
    .OP_OUT(4'hE),
    .OP_HLT(4'hF)
  ) dut (
    .clk(clk), .clr(clr), .opcode(opcode),
    .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .la_n(la_n),
    .lb_n(lb_n), .lo_n(lo_n), .ei_n(ei_n), .ea(ea), .eu(eu), .su(su),
    .halt(halt), .tstate(tstate)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected control word for step t (0 = T1) of an instruction.
  function automatic logic [11:0] exp_cw(input int t, input logic [3:0] op, input bit h);
    bit a_cp = 0, a_ep = 0, a_lm = 0, a_ce = 0, a_li = 0, a_la = 0;
    bit a_lb = 0, a_lo = 0, a_ei = 0, a_ea = 0, a_eu = 0, a_su = 0;
    bit mem = (op == LDA) || (op == ADD) || (op == SUB);
    bit alu = (op == ADD) || (op == SUB);
    if (!h) begin
      if (t == 0) begin a_ep = 1; a_lm = 1; end
      if (t == 1) a_cp = 1;
      if (t == 2) begin a_ce = 1; a_li = 1; end
      if (t == 3 && mem) begin a_ei = 1; a_lm = 1; end
      if (t == 3 && op == OUT) begin a_ea = 1; a_lo = 1; end
      if (t == 4 && op == LDA) begin a_ce = 1; a_la = 1; end
      if (t == 4 && alu) begin a_ce = 1; a_lb = 1; end
      if (t == 5 && alu) begin a_eu = 1; a_la = 1; a_su = (op == SUB); end
    end
    return {a_cp, a_ep, !a_lm, !a_ce, !a_li, !a_la, !a_lb, !a_lo, !a_ei, a_ea, a_eu, a_su};
  endfunction

  task automatic check_all(input string tag);
    logic [5:0] exp_ts;
    exp_ts = 6'b000001 << mt;
    chk({tag, "_ts"}, 32'(tstate), 32'(exp_ts));
    chk({tag, "_halt"}, 32'(halt), 32'(mhalt));
    chk({tag, "_cw"}, 32'(cw), 32'(exp_cw(mt, opcode, mhalt)));
  endtask

  // Called just after a rising edge; returns just after the next rising edge.
  task automatic step(input logic [3:0] op, input string tag);
    opcode = op;
    #1;
    check_all(tag);
    @(negedge clk);
    if (!mhalt) begin
      if (mt == 3 && op == HLT) mhalt = 1'b1;
      else                      mt = (mt + 1) % 6;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input string tag);
    for (int i = 0; i < 6; i++) step(op, tag);
  endtask

  task automatic do_clr(input string tag);
    clr = 1'b0;
    #1;
    mt = 0;
    mhalt = 1'b0;
    chk({tag, "_rts"}, 32'(tstate), 32'h1);
    chk({tag, "_rhalt"}, 32'(halt), 32'h0);
    chk({tag, "_rcw"}, 32'(cw), 32'(INACT));
    clr = 1'b1;
  endtask

  initial begin
    // Reset held across several clock edges.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ts", 32'(tstate), 32'h1);
    chk("rst_halt", 32'(halt), 32'h0);
    chk("rst_cw", 32'(cw), 32'(INACT));
    @(posedge clk);
    #1;
    clr = 1'b1;
    mt = 0;
    mhalt = 1'b0;

    run_instr(LDA, "lda");
    run_instr(SUB, "sub");
    run_instr(ADD, "add");
    run_instr(4'h7, "nop");
    chk("nop_ring", 32'(tstate), 32'h1);

    for (int i = 0; i < 16; i++) step(HLT, "hlt");
    chk("hlt_frozen", 32'(tstate), 32'h08);
    do_clr("hlt_clr");

    // Abort an ADD during T5.
    for (int i = 0; i < 4; i++) step(ADD, "abort");
    opcode = ADD;
    #1;
    chk("abort_lb_pre", 32'(lb_n), 32'h0);
    clr = 1'b0;
    #1;
    chk("abort_ts", 32'(tstate), 32'h1);
    chk("abort_lb", 32'(lb_n), 32'h1);
    clr = 1'b1;
    mt = 0;
    mhalt = 1'b0;

    run_instr(LDA, "b2b_lda");
    run_instr(ADD, "b2b_add");
    run_instr(OUT, "b2b_out");
    chk("b2b_t1", 32'(tstate), 32'h1);

    for (int n = 0; n < 40; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      run_instr(op, "rnd");
      if (mhalt) begin
        for (int i = 0; i < 3; i++) step(4'($urandom_range(0, 15)), "rnd_hlt");
        do_clr("rnd_clr");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
